// File: rtl/y86_pkg.sv
// ============================================================================
// Module : y86_pkg
// Brief  : Shared Y86-64 register ids and default datapath widths.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package y86_pkg;

   localparam int c_DATA_W = 64;
   localparam int c_ADDR_W = 4;

   typedef enum logic [3:0] {
      RAX   = 4'd0,
      RCX   = 4'd1,
      RDX   = 4'd2,
      RBX   = 4'd3,
      RSP   = 4'd4,
      RBP   = 4'd5,
      RSI   = 4'd6,
      RDI   = 4'd7,
      R8    = 4'd8,
      R9    = 4'd9,
      R10   = 4'd10,
      R11   = 4'd11,
      R12   = 4'd12,
      R13   = 4'd13,
      R14   = 4'd14,
      RNONE = 4'd15
   } reg_id_e;

endpackage

`default_nettype wire

// File: rtl/pipe_regfile_sb_sb_counter.sv
// ============================================================================
// Module : sb_counter
// Brief  : Saturating outstanding-write counter, +0..2 / -0..2 per cycle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sb_counter #(
   parameter int CNT_W = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [1:0]       inc,
   input  logic [1:0]       dec,
   output logic [CNT_W-1:0] count,
   output logic             err
);

   localparam logic [CNT_W:0] c_MAX = {1'b0, {CNT_W{1'b1}}};

   logic [CNT_W-1:0] r_count;
   logic [CNT_W:0]   w_sum;
   logic [CNT_W:0]   w_res;
   logic             w_under;
   logic             w_over;
   logic [CNT_W-1:0] w_next;

   // Add before subtracting so a claim and release in one cycle never underflows.
   always_comb begin
      w_sum   = {1'b0, r_count} + (CNT_W+1)'(inc);
      w_under = (w_sum < (CNT_W+1)'(dec));
      w_res   = w_sum - (CNT_W+1)'(dec);
      w_over  = !w_under && (w_res > c_MAX);
      w_next  = w_res[CNT_W-1:0];
      if (w_under) begin
         w_next = '0;
      end else if (w_over) begin
         w_next = '1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_count <= '0;
      end else begin
         r_count <= w_next;
      end
   end

   assign count = r_count;
   assign err   = w_under | w_over;

endmodule

`default_nettype wire

// File: rtl/pipe_regfile_sb.sv
// ============================================================================
// Module : pipe_regfile_sb
// Brief  : Y86-64 register file, 2 read / 2 write ports, RAW scoreboard.
//          Optional same-cycle read bypass: define PIPE_RF_BYPASS_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pipe_regfile_sb
   import y86_pkg::*;
#(
   parameter int DATA_W  = c_DATA_W,
   parameter int NREGS   = 15,
   parameter int ADDR_W  = c_ADDR_W,
   parameter int NONE_ID = 15,
   parameter int CNT_W   = 2
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [ADDR_W-1:0]       src_a,
   output logic [DATA_W-1:0]       val_a,
   output logic                    busy_a,
   input  logic [ADDR_W-1:0]       src_b,
   output logic [DATA_W-1:0]       val_b,
   output logic                    busy_b,
   input  logic [ADDR_W-1:0]       dst_e,
   input  logic [DATA_W-1:0]       val_e,
   input  logic [ADDR_W-1:0]       dst_m,
   input  logic [DATA_W-1:0]       val_m,
   input  logic [ADDR_W-1:0]       claim_e,
   input  logic [ADDR_W-1:0]       claim_m,
   input  logic                    claim_v,
   output logic                    sb_err,
   output logic [NREGS*DATA_W-1:0] regs_flat
);

   if ((NONE_ID < NREGS) || ((2**ADDR_W) <= NREGS)) begin : g_cfg_check
      $error("pipe_regfile_sb: invalid NREGS/ADDR_W/NONE_ID combination");
   end

   logic [DATA_W-1:0] r_regs  [NREGS];
   logic [DATA_W-1:0] w_rd    [NREGS];
   logic [CNT_W-1:0]  w_count [NREGS];
   logic [1:0]        w_inc   [NREGS];
   logic [1:0]        w_dec   [NREGS];
   logic [NREGS-1:0]  w_wr_e;
   logic [NREGS-1:0]  w_wr_m;
   logic [NREGS-1:0]  w_busy;
   logic [NREGS-1:0]  w_err;
   logic              r_sb_err;

   for (genvar i = 0; i < NREGS; i++) begin : g_reg
      localparam logic [ADDR_W-1:0] c_ID = ADDR_W'(i);

      assign w_wr_e[i] = (dst_e == c_ID);
      assign w_wr_m[i] = (dst_m == c_ID);
      assign w_dec[i]  = {1'b0, w_wr_e[i]} + {1'b0, w_wr_m[i]};
      assign w_inc[i]  = {1'b0, claim_v && (claim_e == c_ID)}
                       + {1'b0, claim_v && (claim_m == c_ID)};

      // M is applied last so it wins a double write (popq %rsp).
      always_ff @(posedge clock) begin
         if (reset) begin
            r_regs[i] <= '0;
         end else if (w_wr_m[i]) begin
            r_regs[i] <= val_m;
         end else if (w_wr_e[i]) begin
            r_regs[i] <= val_e;
         end
      end

      sb_counter #(
         .CNT_W (CNT_W)
      ) u_cnt (
         .clock (clock),
         .reset (reset),
         .inc   (w_inc[i]),
         .dec   (w_dec[i]),
         .count (w_count[i]),
         .err   (w_err[i])
      );

`ifdef PIPE_RF_BYPASS_EN
      assign w_rd[i]   = w_wr_m[i] ? val_m : (w_wr_e[i] ? val_e : r_regs[i]);
      assign w_busy[i] = ({2'b00, w_count[i]} != (CNT_W+2)'(w_dec[i]));
`else
      assign w_rd[i]   = r_regs[i];
      assign w_busy[i] = |w_count[i];
`endif

      assign regs_flat[i*DATA_W +: DATA_W] = r_regs[i];
   end

   // Ids outside 0..NREGS-1 match nothing and read back as idle zero.
   always_comb begin
      val_a  = '0;
      busy_a = 1'b0;
      val_b  = '0;
      busy_b = 1'b0;
      for (int i = 0; i < NREGS; i++) begin
         if (src_a == ADDR_W'(i)) begin
            val_a  = w_rd[i];
            busy_a = w_busy[i];
         end
         if (src_b == ADDR_W'(i)) begin
            val_b  = w_rd[i];
            busy_b = w_busy[i];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_sb_err <= 1'b0;
      end else begin
         r_sb_err <= r_sb_err | (|w_err);
      end
   end

   assign sb_err = r_sb_err;

endmodule

`default_nettype wire

// File: tb/tb_pipe_regfile_sb.sv
// ============================================================================
// Module : tb_pipe_regfile_sb
// Brief  : Directed self-checking bench for pipe_regfile_sb.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_regfile_sb;
   import y86_pkg::*;

   localparam int DATA_W = 64;
   localparam int NREGS  = 15;
   localparam int ADDR_W = 4;

   logic                    clock;
   logic                    reset;
   logic [ADDR_W-1:0]       src_a, src_b, dst_e, dst_m, claim_e, claim_m;
   logic [DATA_W-1:0]       val_a, val_b, val_e, val_m;
   logic                    busy_a, busy_b, claim_v, sb_err;
   logic [NREGS*DATA_W-1:0] regs_flat;

   int n_cmp = 0;
   int n_bad = 0;
`ifdef PIPE_RF_BYPASS_EN
   localparam bit c_BYP = 1'b1;
`else
   localparam bit c_BYP = 1'b0;
`endif

   pipe_regfile_sb u_dut (
      .clock     (clock),
      .reset     (reset),
      .src_a     (src_a),
      .val_a     (val_a),
      .busy_a    (busy_a),
      .src_b     (src_b),
      .val_b     (val_b),
      .busy_b    (busy_b),
      .dst_e     (dst_e),
      .val_e     (val_e),
      .dst_m     (dst_m),
      .val_m     (val_m),
      .claim_e   (claim_e),
      .claim_m   (claim_m),
      .claim_v   (claim_v),
      .sb_err    (sb_err),
      .regs_flat (regs_flat)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      dst_e   = RNONE;  val_e = '0;
      dst_m   = RNONE;  val_m = '0;
      claim_e = RNONE;  claim_m = RNONE;
      claim_v = 1'b0;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      idle();
      src_a = RAX;
      src_b = RAX;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;

      // Reset state across every id, including out-of-range RNONE
      for (int i = 0; i < 16; i++) begin
         src_a = ADDR_W'(i);
         src_b = ADDR_W'(15 - i);
         #1;
         check($sformatf("rst_val_a[%0d]", i), val_a, 64'h0);
         check($sformatf("rst_busy_a[%0d]", i), {63'b0, busy_a}, 64'h0);
         check($sformatf("rst_val_b[%0d]", 15 - i), val_b, 64'h0);
         check($sformatf("rst_busy_b[%0d]", 15 - i), {63'b0, busy_b}, 64'h0);
      end
      check("rst_sb_err", {63'b0, sb_err}, 64'h0);
      check("rst_flat_zero", {63'b0, |regs_flat}, 64'h0);

      // Double write to RAX: M wins
      claim_v = 1'b1; claim_e = RAX; claim_m = RAX;
      tick();
      idle();
      src_a = RAX;
      #1;
      check("rax_busy_claimed", {63'b0, busy_a}, 64'h1);
      dst_e = RAX; val_e = 64'h11;
      dst_m = RAX; val_m = 64'h22;
      tick();
      idle();
      check("rax_m_priority", val_a, 64'h22);
      check("rax_flat", regs_flat[0 +: 64], 64'h22);
      check("rax_busy_released", {63'b0, busy_a}, 64'h0);
      check("rax_no_err", {63'b0, sb_err}, 64'h0);
      src_a = RNONE;
      #1;
      check("none_reads_zero", val_a, 64'h0);

      // Gated claim is ignored
      claim_e = RSP; claim_m = RSP; claim_v = 1'b0;
      src_b = RSP;
      tick();
      idle();
      check("gated_claim", {63'b0, busy_b}, 64'h0);

      // popq %rsp: two claims, released E then M
      claim_v = 1'b1; claim_e = RSP; claim_m = RSP;
      tick();
      idle();
      check("rsp_busy_2", {63'b0, busy_b}, 64'h1);
      dst_e = RSP; val_e = 64'h100;
      tick();
      idle();
      check("rsp_busy_1", {63'b0, busy_b}, 64'h1);
      check("rsp_val_e", val_b, 64'h100);
      dst_m = RSP; val_m = 64'h200;
      tick();
      idle();
      check("rsp_busy_0", {63'b0, busy_b}, 64'h0);
      check("rsp_val_m", val_b, 64'h200);
      check("rsp_flat", regs_flat[4*64 +: 64], 64'h200);

      // RCX: claim and release in the same cycle net out
      src_a = RCX;
      claim_v = 1'b1; claim_e = RCX;
      tick();
      idle();
      claim_v = 1'b1; claim_m = RCX;
      dst_e = RCX; val_e = 64'h55;
      tick();
      idle();
      check("rcx_net_busy", {63'b0, busy_a}, 64'h1);
      check("rcx_net_val", val_a, 64'h55);
      check("rcx_net_err", {63'b0, sb_err}, 64'h0);
      dst_m = RCX; val_m = 64'h66;
      tick();
      idle();
      check("rcx_released", {63'b0, busy_a}, 64'h0);
      check("rcx_val_m", val_a, 64'h66);

      // R8: seed value, then two outstanding claims and same-cycle writes
      src_a = R8;
      claim_v = 1'b1; claim_e = R8;
      tick();
      idle();
      dst_e = R8; val_e = 64'h77;
      tick();
      idle();
      check("r8_seed", val_a, 64'h77);
      claim_v = 1'b1; claim_e = R8; claim_m = R8;
      tick();
      idle();
      dst_e = R8; val_e = 64'hDEAD;
      #1;
      check("r8_same_cycle_e", val_a, c_BYP ? 64'hDEAD : 64'h77);
      check("r8_same_cycle_busy_e", {63'b0, busy_a}, 64'h1);
      dst_m = R8; val_m = 64'hBEEF;
      #1;
      check("r8_same_cycle_m", val_a, c_BYP ? 64'hBEEF : 64'h77);
      check("r8_same_cycle_busy_em", {63'b0, busy_a}, c_BYP ? 64'h0 : 64'h1);
      tick();
      idle();
      check("r8_after_edge", val_a, 64'hBEEF);
      check("r8_busy_after", {63'b0, busy_a}, 64'h0);
      check("r8_no_err", {63'b0, sb_err}, 64'h0);

      // Underflow: release RDX with nothing outstanding
      src_a = RDX;
      dst_e = RDX; val_e = 64'h99;
      tick();
      idle();
      check("rdx_underflow_err", {63'b0, sb_err}, 64'h1);
      check("rdx_count_zero", {63'b0, busy_a}, 64'h0);
      claim_v = 1'b1; claim_e = RDX;
      tick();
      idle();
      check("rdx_count_held_0", {63'b0, busy_a}, 64'h1);
      dst_m = RDX; val_m = 64'h9A;
      tick();
      idle();
      tick();
      tick();
      check("sb_err_sticky", {63'b0, sb_err}, 64'h1);
      check("rdx_busy_clear", {63'b0, busy_a}, 64'h0);

      // Reset clears everything, including sticky error
      claim_v = 1'b1; claim_e = RBX; claim_m = RBX;
      dst_e = RAX; val_e = 64'h1234;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      idle();
      src_a = RAX; src_b = RBX;
      #1;
      check("reset2_sb_err", {63'b0, sb_err}, 64'h0);
      check("reset2_rax", val_a, 64'h0);
      check("reset2_rbx_claim_ignored", {63'b0, busy_b}, 64'h0);
      check("reset2_flat_zero", {63'b0, |regs_flat}, 64'h0);

      // Overflow: four claims on RBX saturate at 3
      claim_v = 1'b1; claim_e = RBX; claim_m = RBX;
      tick();
      check("rbx_2_no_err", {63'b0, sb_err}, 64'h0);
      tick();
      idle();
      check("rbx_overflow_err", {63'b0, sb_err}, 64'h1);
      dst_e = RBX; dst_m = RBX;
      tick();
      idle();
      check("rbx_sat_busy_1", {63'b0, busy_b}, 64'h1);
      dst_e = RBX;
      tick();
      idle();
      check("rbx_sat_busy_0", {63'b0, busy_b}, 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
